wb_uart8_tx: RTL and testbench
==============================

Name: wb_uart8_tx

Overview:
8-bit Wishbone B3 slave that terminates the narrow side of the 32-to-8 data resizer on the UART port. CPU writes are queued in a TX FIFO and serialised as 8N1 frames on tx_o. Software controls it through a small register file for the baud divisor, enable, status and interrupt. Receive is out of scope; this block is the transmit end only.

Parameters:
CLK_DIV, 16'd27, reset value of the baud divisor (clocks per serial bit); a divisor of 0 is treated as 1.
FIFO_AW, 4, log2 of TX FIFO depth (default depth 16).

Ports:
wb_clk_i  in  1  system clock; all logic is on the rising edge.
wb_rst_i  in  1  asynchronous, active-low reset.
wb_adr_i  in  32  byte address; only [2:0] is decoded.
wb_dat_i  in  8  write data.
wb_we_i  in  1  write enable.
wb_cyc_i  in  1  bus cycle.
wb_stb_i  in  1  strobe.
wb_cti_i  in  3  ignored; every access is treated as classic.
wb_bte_i  in  2  ignored.
wb_dat_o  out  8  read data.
wb_ack_o  out  1  transfer acknowledge.
wb_err_o  out  1  tied 0.
wb_rty_o  out  1  tied 0.
tx_o  out  1  serial output; idles high.
irq_o  out  1  level interrupt.

Behaviour:
- Reset (async, wb_rst_i=0):
  - tx_o=1, wb_ack_o=0, wb_dat_o=0, irq_o=0.
  - FIFO empty, overflow=0, divisor=CLK_DIV, tx_en=1, irq_en=0, FSM in IDLE.
  - Reset asserted mid-frame returns tx_o to 1 immediately and discards FIFO contents.
- Bus handshake:
  - A request is sampled at an edge where cyc&stb&!ack holds. wb_ack_o is registered high for exactly one cycle after that edge, giving one wait state.
  - Back-to-back requests are acked every second cycle.
  - Register side effects (push, clear, divisor load) and wb_dat_o update on the same edge that raises ack.
- Register map (adr[2:0]):
  - 0 TXDATA: a write pushes the byte; a read returns 0.
  - 1 STATUS: read {4'b0, overflow, busy, empty, full}. Writing bit3=1 clears overflow; other bits are read-only.
  - 2 DIV_LO: read/write divisor[7:0].
  - 3 DIV_HI: read/write divisor[15:8].
  - 4 CTRL: bit0 tx_en, bit1 irq_en; read back in the same positions.
  - 5-7: read 0, writes ignored, still acked.
- FIFO:
  - Depth 2**FIFO_AW, pointers one bit wider than the address, wrap modulo 2**(FIFO_AW+1).
  - Full/empty are evaluated on the pre-edge state. A push while full is dropped and sets overflow (sticky), even if a pop occurs on the same edge.
  - Simultaneous push and pop while not full: both take effect and the count is unchanged.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: if tx_en=1 and the FIFO is not empty, pop into the shift register, latch the divisor as bit_div, clear the bit counter and go to START.
  - START: tx_o=0 for bit_div clocks.
  - DATA: 8 bits, LSB first, bit_div clocks each.
  - STOP: tx_o=1 for bit_div clocks, then IDLE. The next frame may start on the following edge, so frames are gapless.
  - The divisor is sampled only at frame start; DIV writes take effect on the next frame.
  - Clearing tx_en mid-frame lets the current frame complete; no further pops occur.
- busy = (state != IDLE).
- irq_o (registered) = irq_en & empty & !busy.
- Latency: with an empty FIFO, idle FSM and tx_en=1, tx_o falls 2 edges after the write request is sampled. Frame length is 10*bit_div clocks.

Test Plan:
- Reset: hold wb_rst_i=0 mid-frame, then release → tx_o=1, STATUS reads 0x02, DIV_LO/DIV_HI read 0x1B/0x00, CTRL reads 0x01.
- Single byte: write 0x55 to adr 0 with divisor 4 → ack 1 cycle after the request; tx_o low 2 edges after the request; then bits 1,0,1,0,1,0,1,0 and a stop bit, each 4 clocks, 40 clocks total.
- Gapless back-to-back: write 0x00 then 0xFF with divisor 2 → the start bit of the second frame follows the first stop bit with zero idle cycles; STATUS.busy=1 throughout both frames.
- Overflow: with tx_en=0, write 17 bytes to a 16-deep FIFO → STATUS reads 0x09 (full plus overflow); write 0x08 to STATUS → reads 0x01; set tx_en=1 → exactly 16 frames sent, the 17th byte is absent.
- Divisor change mid-frame: change DIV_LO from 3 to 5 during frame 1 → frame 1 uses 3 clocks/bit, frame 2 uses 5 clocks/bit.
- IRQ and unmapped access: set CTRL=0x03, send 1 byte → irq_o=0 while busy, 1 a cycle after STOP ends; a read of adr 6 acks with 0x00.

Source files
------------

// File: rtl/wb_uart8_tx.sv
// wb_uart8_tx: transmit-only 8N1 UART behind an 8-bit Wishbone B3 slave.
// Bytes written to TXDATA are queued in a TX FIFO and serialised on tx_o.
// Each accepted request is acked once, one cycle after it is sampled, so
// every access has one wait state.
//
// Ports:
//   wb_clk_i  system clock, rising edge
//   wb_rst_i  asynchronous reset, active low
//   wb_adr_i  byte address, only [2:0] decoded
//   wb_dat_i  write data
//   wb_we_i   write enable
//   wb_cyc_i  bus cycle
//   wb_stb_i  strobe
//   wb_cti_i  cycle type, ignored (classic only)
//   wb_bte_i  burst type, ignored
//   wb_dat_o  registered read data
//   wb_ack_o  registered acknowledge
//   wb_err_o  tied low
//   wb_rty_o  tied low
//   tx_o      serial output, idles high
//   irq_o     level interrupt: irq_en & FIFO empty & transmitter idle
//
// Register map (adr[2:0]):
//   0 TXDATA  write pushes a byte, reads 0
//   1 STATUS  {4'b0, overflow, busy, empty, full}; write bit3=1 clears overflow
//   2 DIV_LO  divisor[7:0]
//   3 DIV_HI  divisor[15:8]
//   4 CTRL    bit0 tx_en, bit1 irq_en
//   5-7       read 0, writes ignored
module wb_uart8_tx #(
    parameter logic [15:0] CLK_DIV = 16'd27,
    parameter int          FIFO_AW = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [7:0]  wb_dat_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [7:0]  wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic        tx_o,
    output logic        irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int DEPTH = 1 << FIFO_AW;

    // A divisor of zero behaves like one clock per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        eff_div = (d == 16'd0) ? 16'd1 : d;
    endfunction

    logic [7:0]       fifo_mem_r [0:DEPTH-1];
    logic [FIFO_AW:0] wr_ptr_r;
    logic [FIFO_AW:0] rd_ptr_r;
    logic             full_s;
    logic             empty_s;
    logic             push_req_s;
    logic             push_s;
    logic             pop_s;

    logic             req_s;
    logic             ack_r;
    logic [7:0]       dat_r;
    logic [7:0]       rdata_s;
    logic [15:0]      div_r;
    logic             tx_en_r;
    logic             irq_en_r;
    logic             ovf_r;
    logic             irq_r;

    tx_state_t        state_r;
    tx_state_t        state_nxt;
    logic [15:0]      cnt_r;
    logic [15:0]      cnt_nxt;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_nxt;
    logic [7:0]       shift_r;
    logic [7:0]       shift_nxt;
    logic [15:0]      bit_div_r;
    logic [15:0]      bit_div_nxt;
    logic             tx_r;
    logic             tx_s;
    logic             bit_end_s;
    logic             start_ok_s;
    logic             busy_s;
    logic             unused_s;

    assign unused_s   = ^{wb_adr_i[31:3], wb_cti_i, wb_bte_i};

    // A new request is only taken while ack is low, which yields one wait state
    // and acks every second cycle for back-to-back strobes.
    assign req_s      = wb_cyc_i & wb_stb_i & ~ack_r;
    assign push_req_s = req_s & wb_we_i & (wb_adr_i[2:0] == 3'd0);
    assign push_s     = push_req_s & ~full_s;

    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign full_s     = (wr_ptr_r[FIFO_AW] != rd_ptr_r[FIFO_AW]) &&
                        (wr_ptr_r[FIFO_AW-1:0] == rd_ptr_r[FIFO_AW-1:0]);
    assign busy_s     = (state_r != ST_IDLE);
    assign start_ok_s = tx_en_r & ~empty_s;
    assign bit_end_s  = (cnt_r == (bit_div_r - 16'd1));

    assign wb_dat_o   = dat_r;
    assign wb_ack_o   = ack_r;
    assign wb_err_o   = 1'b0;
    assign wb_rty_o   = 1'b0;
    assign tx_o       = tx_r;
    assign irq_o      = irq_r;

    // Read data multiplexer on the pre-edge register state.
    always_comb begin
        rdata_s = 8'd0;
        case (wb_adr_i[2:0])
            3'd1:    rdata_s = {4'b0000, ovf_r, busy_s, empty_s, full_s};
            3'd2:    rdata_s = div_r[7:0];
            3'd3:    rdata_s = div_r[15:8];
            3'd4:    rdata_s = {6'b000000, irq_en_r, tx_en_r};
            default: rdata_s = 8'd0;
        endcase
    end

    // Bus acknowledge and read data registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            ack_r <= 1'b0;
            dat_r <= 8'd0;
        end else begin
            ack_r <= req_s;
            if (req_s) begin
                dat_r <= rdata_s;
            end
        end
    end

    // Software-visible control registers and the sticky overflow flag.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            div_r    <= CLK_DIV;
            tx_en_r  <= 1'b1;
            irq_en_r <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            if (push_req_s && full_s) begin
                ovf_r <= 1'b1;
            end else if (req_s && wb_we_i && (wb_adr_i[2:0] == 3'd1) && wb_dat_i[3]) begin
                ovf_r <= 1'b0;
            end
            if (req_s && wb_we_i) begin
                case (wb_adr_i[2:0])
                    3'd2:    div_r[7:0]  <= wb_dat_i;
                    3'd3:    div_r[15:8] <= wb_dat_i;
                    3'd4: begin
                        tx_en_r  <= wb_dat_i[0];
                        irq_en_r <= wb_dat_i[1];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Interrupt is registered from the pre-edge FIFO and FSM state.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_en_r & empty_s & ~busy_s;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge wb_clk_i) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[FIFO_AW-1:0]] <= wb_dat_i;
        end
    end

    // FIFO pointers; one extra bit distinguishes full from empty.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

    // TX FSM next state, datapath next values and line level.
    always_comb begin
        state_nxt   = state_r;
        cnt_nxt     = cnt_r;
        bit_idx_nxt = bit_idx_r;
        shift_nxt   = shift_r;
        bit_div_nxt = bit_div_r;
        pop_s       = 1'b0;
        tx_s        = 1'b1;
        case (state_r)
            ST_IDLE: begin
                tx_s = 1'b1;
                if (start_ok_s) begin
                    pop_s       = 1'b1;
                    shift_nxt   = fifo_mem_r[rd_ptr_r[FIFO_AW-1:0]];
                    bit_div_nxt = eff_div(div_r);
                    cnt_nxt     = 16'd0;
                    bit_idx_nxt = 3'd0;
                    state_nxt   = ST_START;
                end else begin
                    state_nxt   = ST_IDLE;
                end
            end
            ST_START: begin
                tx_s = 1'b0;
                if (bit_end_s) begin
                    cnt_nxt     = 16'd0;
                    bit_idx_nxt = 3'd0;
                    state_nxt   = ST_DATA;
                end else begin
                    cnt_nxt     = cnt_r + 16'd1;
                end
            end
            ST_DATA: begin
                tx_s = shift_r[0];
                if (bit_end_s) begin
                    cnt_nxt   = 16'd0;
                    shift_nxt = {1'b0, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_nxt = ST_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt_r + 16'd1;
                end
            end
            ST_STOP: begin
                tx_s = 1'b1;
                if (bit_end_s) begin
                    // Chain straight into the next start bit so frames are gapless.
                    if (start_ok_s) begin
                        pop_s       = 1'b1;
                        shift_nxt   = fifo_mem_r[rd_ptr_r[FIFO_AW-1:0]];
                        bit_div_nxt = eff_div(div_r);
                        cnt_nxt     = 16'd0;
                        bit_idx_nxt = 3'd0;
                        state_nxt   = ST_START;
                    end else begin
                        cnt_nxt     = 16'd0;
                        state_nxt   = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt_r + 16'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // TX FSM state and datapath registers; tx_o is the registered line level.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            bit_div_r <= eff_div(CLK_DIV);
            tx_r      <= 1'b1;
        end else begin
            state_r   <= state_nxt;
            cnt_r     <= cnt_nxt;
            bit_idx_r <= bit_idx_nxt;
            shift_r   <= shift_nxt;
            bit_div_r <= bit_div_nxt;
            tx_r      <= tx_s;
        end
    end

endmodule

// File: tb/tb_wb_uart8_tx.sv
// Self-checking bench for wb_uart8_tx: directed scenarios plus randomized
// bytes/divisors, checked by a frame monitor driven from a byte queue and a
// tracked divisor value.
module tb_wb_uart8_tx;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic [31:0] wb_adr_i;
    logic [7:0]  wb_dat_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic [7:0]  wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;
    logic        tx_o;
    logic        irq_o;

    wb_uart8_tx dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_cti_i (wb_cti_i),
        .wb_bte_i (wb_bte_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .wb_rty_o (wb_rty_o),
        .tx_o     (tx_o),
        .irq_o    (irq_o)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc_cnt = 0;
    logic [7:0]  exp_q [$];
    logic [15:0] m_div;
    logic        mon_en;
    int          frames_started = 0;
    int          frames_done = 0;
    int          last_gap = 0;
    int          idle_run = 0;
    int          start_cyc = 0;

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame monitor: a low sample while idle is a start bit; the frame is then
    // compared cycle by cycle against {stop, byte, start} at the divisor
    // software had programmed when the frame began.
    initial begin : monitor
        int         d;
        int         bad;
        logic [9:0] fr;
        logic [7:0] rx;
        logic [7:0] exp_b;
        forever begin
            @(negedge wb_clk_i);
            if (mon_en && tx_o === 1'b0) begin
                frames_started++;
                last_gap  = idle_run;
                start_cyc = cyc_cnt;
                d = (m_div == 16'd0) ? 1 : int'(m_div);
                check_eq("frame_pending", (exp_q.size() > 0) ? 1 : 0, 1);
                exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                fr  = {1'b1, exp_b, 1'b0};
                bad = 0;
                rx  = 8'h00;
                for (int k = 0; k < 10 * d; k++) begin
                    if (k > 0) @(negedge wb_clk_i);
                    if (tx_o !== fr[k / d]) bad++;
                    if ((k % d) == (d / 2) && (k / d) >= 1 && (k / d) <= 8) rx[(k / d) - 1] = tx_o;
                end
                check_eq("frame_data", rx, exp_b);
                check_eq("frame_timing", bad, 0);
                frames_done++;
                idle_run = 0;
            end else begin
                idle_run++;
            end
        end
    end

    task automatic wb_xfer(input logic [2:0] adr, input logic we, input logic [7:0] wd,
                           output logic [7:0] rd, output int req_cyc);
        @(negedge wb_clk_i);
        check_eq("ack_low", wb_ack_o, 1'b0);
        wb_adr_i = {29'd0, adr};
        wb_we_i  = we;
        wb_dat_i = wd;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        @(negedge wb_clk_i);
        req_cyc = cyc_cnt;
        check_eq("ack", wb_ack_o, 1'b1);
        rd = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        if (we && adr == 3'd2) m_div[7:0]  = wd;
        if (we && adr == 3'd3) m_div[15:8] = wd;
    endtask

    task automatic wb_write(input logic [2:0] adr, input logic [7:0] wd);
        logic [7:0] rd;
        int         rc;
        wb_xfer(adr, 1'b1, wd, rd, rc);
    endtask

    task automatic rd_check(input string tag, input logic [2:0] adr, input logic [7:0] exp);
        logic [7:0] rd;
        int         rc;
        wb_xfer(adr, 1'b0, 8'h00, rd, rc);
        check_eq(tag, rd, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back(b);
        wb_write(3'd0, b);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (frames_done < n && t < budget) begin
            @(negedge wb_clk_i);
            t++;
        end
        check_eq("frames_wait", frames_done, n);
    endtask

    initial begin : main
        logic [7:0] rd;
        int         rc;
        int         base;
        int         bad;
        int         acks;
        int         nb;
        logic [7:0] b;
        logic [7:0] dv;

        wb_rst_i = 1'b0;
        wb_adr_i = 32'd0;
        wb_dat_i = 8'd0;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_cti_i = 3'd0;
        wb_bte_i = 2'd0;
        m_div    = 16'd27;
        mon_en   = 1'b0;

        // Reset, then a reset asserted in the middle of a frame.
        repeat (3) @(negedge wb_clk_i);
        check_eq("rst_tx", tx_o, 1'b1);
        check_eq("rst_ack", wb_ack_o, 1'b0);
        check_eq("rst_dat", wb_dat_o, 8'h00);
        check_eq("rst_irq", irq_o, 1'b0);
        wb_rst_i = 1'b1;
        wb_write(3'd0, 8'h00);
        wb_write(3'd0, 8'h3C);
        repeat (50) @(negedge wb_clk_i);
        check_eq("pre_reset_tx", tx_o, 1'b0);
        wb_rst_i = 1'b0;
        #1;
        check_eq("midframe_rst_tx", tx_o, 1'b1);
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        m_div = 16'd27;
        repeat (30) @(negedge wb_clk_i);
        check_eq("rst_discard_tx", tx_o, 1'b1);
        rd_check("rst_status", 3'd1, 8'h02);
        rd_check("rst_div_lo", 3'd2, 8'h1B);
        rd_check("rst_div_hi", 3'd3, 8'h00);
        rd_check("rst_ctrl", 3'd4, 8'h01);
        mon_en = 1'b1;

        // Single byte at divisor 4: start bit two edges after the request.
        wb_write(3'd2, 8'd4);
        base = frames_done;
        exp_q.push_back(8'h55);
        wb_xfer(3'd0, 1'b1, 8'h55, rd, rc);
        rd_check("single_busy", 3'd1, 8'h06);
        wait_frames(base + 1, 200);
        check_eq("single_latency", start_cyc - rc, 2);

        // Gapless back-to-back frames at divisor 2.
        wb_write(3'd2, 8'd2);
        base = frames_done;
        send_byte(8'h00);
        send_byte(8'hFF);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            wb_xfer(3'd1, 1'b0, 8'h00, rd, rc);
            if (rd[2] !== 1'b1) bad++;
        end
        check_eq("gapless_busy", bad, 0);
        wait_frames(base + 2, 200);
        check_eq("gapless_gap", last_gap, 0);

        // Overflow: 17 pushes into a 16-deep FIFO with the transmitter held off.
        wb_write(3'd4, 8'h00);
        base = frames_done;
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            if (i < 16) exp_q.push_back(b);
            wb_write(3'd0, b);
        end
        rd_check("ovf_status", 3'd1, 8'h09);
        wb_write(3'd1, 8'h08);
        rd_check("ovf_clear", 3'd1, 8'h01);
        wb_write(3'd4, 8'h01);
        wait_frames(base + 16, 800);
        repeat (60) @(negedge wb_clk_i);
        check_eq("ovf_no_17th", frames_started, base + 16);

        // Clearing tx_en mid-frame finishes that frame and stops further pops.
        base = frames_done;
        send_byte(8'hA5);
        send_byte(8'h3C);
        for (int t = 0; t < 50 && frames_started < base + 1; t++) @(negedge wb_clk_i);
        wb_write(3'd4, 8'h00);
        repeat (60) @(negedge wb_clk_i);
        check_eq("txen_hold", frames_started, base + 1);
        rd_check("txen_status", 3'd1, 8'h00);
        wb_write(3'd4, 8'h01);
        wait_frames(base + 2, 200);

        // Divisor change during a frame only affects the next frame.
        wb_write(3'd2, 8'd3);
        base = frames_done;
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        wb_write(3'd2, 8'd5);
        wait_frames(base + 2, 300);

        // Interrupt: high when idle and empty, low for the whole frame.
        wb_write(3'd2, 8'd2);
        wb_write(3'd4, 8'h03);
        repeat (2) @(negedge wb_clk_i);
        check_eq("irq_idle", irq_o, 1'b1);
        base = frames_done;
        exp_q.push_back(8'h96);
        wb_xfer(3'd0, 1'b1, 8'h96, rd, rc);
        bad = 0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge wb_clk_i);
            if (irq_o !== ((k == 22) ? 1'b1 : 1'b0)) bad++;
        end
        check_eq("irq_window", bad, 0);
        check_eq("irq_after_stop", irq_o, 1'b1);
        wait_frames(base + 1, 50);

        // Unmapped and read-as-zero accesses.
        wb_write(3'd5, 8'hFF);
        rd_check("unmapped_rd6", 3'd6, 8'h00);
        rd_check("txdata_rd", 3'd0, 8'h00);
        rd_check("ctrl_after_unmapped", 3'd4, 8'h03);

        // Held strobe: acks alternate, one every second cycle.
        @(negedge wb_clk_i);
        wb_adr_i = 32'd2;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge wb_clk_i);
            if (wb_ack_o === 1'b1) acks++;
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        check_eq("b2b_acks", acks, 3);
        @(negedge wb_clk_i);

        // Randomized bytes at random small divisors, including zero.
        for (int r = 0; r < 4; r++) begin
            dv = 8'($urandom_range(0, 3));
            wb_write(3'd2, dv);
            wb_write(3'd3, 8'h00);
            rd_check("rand_div_rb", 3'd2, m_div[7:0]);
            base = frames_done;
            nb = $urandom_range(1, 4);
            for (int i = 0; i < nb; i++) send_byte(8'($urandom));
            wait_frames(base + nb, 400);
        end
        check_eq("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
